// File: rtl/hpdmc_pkg.sv
// rtl/hpdmc_pkg.sv - shared constants and state encoding for the SDRAM bank manager
package hpdmc_pkg;

  localparam int NBANKS        = 4;
  localparam int ROW_W_DEFAULT = 13;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    TRP,
    ACT,
    TRCD,
    PALL,
    TRPALL,
    REFOK
  } state_t;

endpackage

// File: rtl/hpdmc_delaycnt.sv
// rtl/hpdmc_delaycnt.sv - loadable down-counter shared by the tRP/tRCD waits
// done is high while the remaining count is 0 or 1, so a load of N gives max(N,1) wait cycles.
module hpdmc_delaycnt #(
  parameter int TIM_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TIM_W-1:0] value,
  output logic             done
);

  logic [TIM_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - TIM_W'(1);
    end
  end

  assign done = (cnt <= TIM_W'(1));

endmodule

// File: rtl/hpdmc_bankmgr.sv
// rtl/hpdmc_bankmgr.sv - per-bank open-row tracking and PRECHARGE/ACTIVATE/PRECHARGE-ALL issue
// Commands are held until cmd_ack; the target bank/row are latched when a request leaves IDLE.
module hpdmc_bankmgr
  import hpdmc_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEFAULT,
  parameter int TIM_W = 3
) (
  input  logic             sys_clk,
  input  logic             sdram_rst,
  input  logic [TIM_W-1:0] tim_rp,
  input  logic [TIM_W-1:0] tim_rcd,
  input  logic             req_valid,
  input  logic [1:0]       req_bank,
  input  logic [ROW_W-1:0] req_row,
  output logic             req_ready,
  input  logic [3:0]       precharge_safe,
  output logic             cmd_pre,
  output logic             cmd_act,
  output logic             cmd_pall,
  output logic [1:0]       cmd_bank,
  output logic [ROW_W-1:0] cmd_row,
  input  logic             cmd_ack,
  input  logic             refresh_req,
  output logic             refresh_ready
);

  state_t            state;
  logic [NBANKS-1:0] bank_open;
  logic [ROW_W-1:0]  row_tab [NBANKS];

  logic             hit;
  logic             pre_fire;
  logic             act_fire;
  logic             pall_fire;
  logic             cnt_load;
  logic [TIM_W-1:0] cnt_value;
  logic             cnt_done;

  assign hit       = bank_open[req_bank] && (row_tab[req_bank] == req_row);
  assign pre_fire  = (state == PRE) && precharge_safe[cmd_bank] && cmd_ack;
  assign act_fire  = (state == ACT) && cmd_ack;
  assign pall_fire = (state == PALL) && (&precharge_safe) && cmd_ack;

  // The ACT exit loads tRCD; both precharge exits load tRP.
  assign cnt_load  = pre_fire || act_fire || pall_fire;
  assign cnt_value = (state == ACT) ? tim_rcd : tim_rp;

  hpdmc_delaycnt #(
    .TIM_W(TIM_W)
  ) u_delaycnt (
    .clk  (sys_clk),
    .rst  (sdram_rst),
    .load (cnt_load),
    .value(cnt_value),
    .done (cnt_done)
  );

  assign req_ready     = (state == IDLE) && req_valid && hit && !refresh_req;
  assign cmd_pre       = (state == PRE) && precharge_safe[cmd_bank];
  assign cmd_act       = (state == ACT);
  assign cmd_pall      = (state == PALL) && (&precharge_safe);
  assign refresh_ready = (state == REFOK);

  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state     <= IDLE;
      bank_open <= '0;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      for (int i = 0; i < NBANKS; i++) begin
        row_tab[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (refresh_req) begin
            state <= PALL;
          end else if (req_valid && !hit) begin
            cmd_bank <= req_bank;
            cmd_row  <= req_row;
            state    <= bank_open[req_bank] ? PRE : ACT;
          end
        end
        PRE: begin
          if (pre_fire) begin
            bank_open[cmd_bank] <= 1'b0;
            state               <= TRP;
          end
        end
        TRP: begin
          if (cnt_done) state <= ACT;
        end
        ACT: begin
          if (act_fire) begin
            bank_open[cmd_bank] <= 1'b1;
            row_tab[cmd_bank]   <= cmd_row;
            state               <= TRCD;
          end
        end
        TRCD: begin
          if (cnt_done) state <= IDLE;
        end
        PALL: begin
          if (pall_fire) begin
            bank_open <= '0;
            state     <= TRPALL;
          end
        end
        TRPALL: begin
          if (cnt_done) state <= REFOK;
        end
        REFOK: begin
          if (!refresh_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
